rll27_decoder: RTL
==================

Name: rll27_decoder

Overview:
- Receive-side counterpart of the team's RLL(2,7) encoder. Accepts one NRZI line level per strobed clock.
- Recovers channel bits and parses the variable-length RLL(2,7) codewords. Emits the decoded data bits as a parallel word with a length tag.
- Flags code violations and run-length (d=2, k=7) violations.
- Sits between the line sampler and the downstream data sink in the RLL link.

Parameters:
- WCNT_W, 16, width of the decoded-word counter (wraps modulo 2^WCNT_W).

Ports:
- clk_i  in  1  system clock, rising edge.
- ari  in  1  asynchronous active-low reset.
- line_i  in  1  NRZI line level (channel bit); sampled only when line_vld_i=1.
- line_vld_i  in  1  channel-bit strobe; when low, all state holds.
- data_o  out  4  decoded data bits, right-aligned; first-received data bit is data_o[len_o-1]; unused upper bits are 0.
- len_o  out  3  number of valid bits in data_o (2, 3 or 4).
- valid_o  out  1  one-cycle pulse: data_o/len_o hold a new word.
- code_err_o  out  1  one-cycle pulse: 8 channel bits matched no codeword.
- rll_err_o  out  1  one-cycle pulse: zero run <2 between ones, or >7 zeros.
- word_cnt_o  out  WCNT_W  count of words decoded since reset.

Behaviour:
- Reset (ari low, asynchronous):
  - data_o=0, len_o=0, valid_o=0, code_err_o=0, rll_err_o=0, word_cnt_o=0.
  - prev_level=0, shift register cleared, channel-bit count=0, zero-run count=0, run checker disarmed.
- NRZI recovery, on each cycle with line_vld_i=1:
  - c = line_i XOR prev_level; prev_level <= line_i.
  - c=1 means reversal (R), c=0 means no reversal (N).
- Parser: c shifts into an 8-bit register, LSB = newest. The count increments 1..8. Codewords are checked only when the count reaches 4, 6 or 8 (the code is prefix-free).
  - count 4: 0100 -> "10"; 1000 -> "11".
  - count 6: 000100 -> "000"; 100100 -> "010"; 001000 -> "011".
  - count 8: 00100100 -> "0010"; 00001000 -> "0011".
- On a match:
  - Next cycle: valid_o=1, data_o/len_o set, word_cnt_o+1.
  - Count and register clear in the same edge, so the next channel bit starts a new codeword with no gap.
- On count 8 with no match:
  - Next cycle: code_err_o=1.
  - Count and register clear; no valid_o; word_cnt_o unchanged.
- Output timing and holding:
  - Latency is 1 clock from the strobed edge carrying the last channel bit of a codeword.
  - data_o and len_o hold their last value until the next valid_o; valid_o is never asserted for more than one cycle per word.
- Run-length checker:
  - Arms on the first c=1 after reset; zero-run counter saturates at 8.
  - When armed: c=1 with zero-run <2 produces rll_err_o the next cycle.
  - When armed: zero-run reaching 8 produces rll_err_o once the next cycle, then stays quiet until the next 1.
  - Every c=1 resets the zero-run counter to 0.
  - The checker is independent of the parser; both errors may pulse in the same cycle.
- Gaps and wrap:
  - line_vld_i=0 holds all state, with all pulse outputs 0 that cycle (except the registered pulse from the previous strobe).
  - word_cnt_o wraps from all-ones to 0 without a flag.
- Reset mid-codeword: the partial codeword is discarded with no pulse. Decoding restarts with prev_level=0.

Test Plan:
- Reset values: hold ari low 3 clocks, drive toggling line_i -> all outputs 0, word_cnt_o=0; after release, no pulse until a full codeword arrives.
- Single 2-bit word: after reset, drive line_i=1,1,1,1 (code 1000) -> one cycle after 4th strobe, valid_o=1, data_o=4'b0011, len_o=2, word_cnt_o=1.
- Back-to-back words: drive line_i=0,1,1,1, 1,1,1,0,0,0 (code 0100 000100) -> valid_o with data_o=4'b0010/len 2, then valid_o with data_o=4'b0000/len 3; word_cnt_o=2; no errors.
- 4-bit word with strobe gaps: drive line_i=0,0,1,1,1,0,0,0 (code 00100100), line_vld_i low for 2 cycles between bits 3 and 4 -> valid_o after 8th strobe, data_o=4'b0010, len_o=4.
- Violations: drive line_i=1,0,1,0,1,0,1,0 (code 11111111) -> rll_err_o one cycle after 2nd strobe; code_err_o one cycle after 8th strobe; no valid_o; word_cnt_o unchanged.
- Reset mid-codeword: 3 bits of 000100, then pulse ari low, then line_i=1,1,1,1 -> no pulses for the partial word; valid_o with data_o=4'b0011, len_o=2.

Source files
------------

// File: rtl/rll27_decoder.sv
// RLL(2,7) receive decoder: NRZI line level -> channel bits -> variable-length data words with code and run-length error flags.
// Output pulses are registered one clock after the strobed edge; line_vld_i low freezes all state (no backpressure).
module rll27_decoder #(
  parameter int WCNT_W = 16
) (
  input  logic              clk_i,
  input  logic              ari,
  input  logic              line_i,
  input  logic              line_vld_i,
  output logic [3:0]        data_o,
  output logic [2:0]        len_o,
  output logic              valid_o,
  output logic              code_err_o,
  output logic              rll_err_o,
  output logic [WCNT_W-1:0] word_cnt_o
);

  logic       prev_level;
  logic [7:0] sh_q;
  logic [3:0] cnt_q;
  logic [3:0] zrun_q;
  logic       armed_q;

  logic       c;
  logic [7:0] sh_nxt;
  logic [3:0] cnt_nxt;
  logic       hit;
  logic       miss;
  logic [3:0] dec_dat;
  logic [2:0] dec_len;
  logic [3:0] zrun_nxt;
  logic       rll_hit;

  // Codeword parsing; the code is prefix-free so each length is checked independently.
  always_comb begin
    c       = line_i ^ prev_level;
    sh_nxt  = {sh_q[6:0], c};
    cnt_nxt = cnt_q + 4'd1;
    hit     = 1'b0;
    dec_dat = 4'd0;
    dec_len = 3'd0;
    case (cnt_nxt)
      4'd4: begin
        if (sh_nxt[3:0] == 4'b0100) begin
          hit = 1'b1; dec_dat = 4'b0010; dec_len = 3'd2;
        end else if (sh_nxt[3:0] == 4'b1000) begin
          hit = 1'b1; dec_dat = 4'b0011; dec_len = 3'd2;
        end
      end
      4'd6: begin
        if (sh_nxt[5:0] == 6'b000100) begin
          hit = 1'b1; dec_dat = 4'b0000; dec_len = 3'd3;
        end else if (sh_nxt[5:0] == 6'b100100) begin
          hit = 1'b1; dec_dat = 4'b0010; dec_len = 3'd3;
        end else if (sh_nxt[5:0] == 6'b001000) begin
          hit = 1'b1; dec_dat = 4'b0011; dec_len = 3'd3;
        end
      end
      4'd8: begin
        if (sh_nxt == 8'b00100100) begin
          hit = 1'b1; dec_dat = 4'b0010; dec_len = 3'd4;
        end else if (sh_nxt == 8'b00001000) begin
          hit = 1'b1; dec_dat = 4'b0011; dec_len = 3'd4;
        end
      end
      default: ;
    endcase
    miss = (cnt_nxt == 4'd8) && !hit;
  end

  // Run-length check: zero-run saturates at 8 so the k violation fires exactly once per run.
  always_comb begin
    zrun_nxt = zrun_q;
    rll_hit  = 1'b0;
    if (c) begin
      zrun_nxt = 4'd0;
      rll_hit  = armed_q && (zrun_q < 4'd2);
    end else begin
      zrun_nxt = (zrun_q == 4'd8) ? 4'd8 : zrun_q + 4'd1;
      rll_hit  = armed_q && (zrun_q == 4'd7);
    end
  end

  always_ff @(posedge clk_i or negedge ari) begin
    if (!ari) begin
      prev_level <= 1'b0;
      sh_q       <= 8'd0;
      cnt_q      <= 4'd0;
      zrun_q     <= 4'd0;
      armed_q    <= 1'b0;
      data_o     <= 4'd0;
      len_o      <= 3'd0;
      valid_o    <= 1'b0;
      code_err_o <= 1'b0;
      rll_err_o  <= 1'b0;
      word_cnt_o <= '0;
    end else begin
      valid_o    <= line_vld_i && hit;
      code_err_o <= line_vld_i && miss;
      rll_err_o  <= line_vld_i && rll_hit;
      if (line_vld_i) begin
        prev_level <= line_i;
        zrun_q     <= zrun_nxt;
        if (c) armed_q <= 1'b1;
        if (hit || miss) begin
          sh_q  <= 8'd0;
          cnt_q <= 4'd0;
        end else begin
          sh_q  <= sh_nxt;
          cnt_q <= cnt_nxt;
        end
        if (hit) begin
          data_o     <= dec_dat;
          len_o      <= dec_len;
          word_cnt_o <= word_cnt_o + WCNT_W'(1);
        end
      end
    end
  end

endmodule
